// File: rtl/int_exec_unit_pkg.sv
// -----------------------------------------------------------------------------
// int_exec_unit_pkg
// Shared definitions for the integer execution unit and its neighbours:
//   - exception-type codes carried on the RS issue/commit buses
//   - opgen (operation) encodings shared with the RS and decoder
// -----------------------------------------------------------------------------
package int_exec_unit_pkg;

    localparam int EXC_CODE_W   = 4;
    localparam int OPGEN_CODE_W = 5;

    localparam logic [EXC_CODE_W-1:0] EXC_NONE     = 4'h0;
    localparam logic [EXC_CODE_W-1:0] EXC_OVERFLOW = 4'hC;

    typedef enum logic [OPGEN_CODE_W-1:0] {
        OP_ADD  = 5'd0,
        OP_ADDU = 5'd1,
        OP_SUB  = 5'd2,
        OP_SUBU = 5'd3,
        OP_AND  = 5'd4,
        OP_OR   = 5'd5,
        OP_XOR  = 5'd6,
        OP_NOR  = 5'd7,
        OP_SLT  = 5'd8,
        OP_SLTU = 5'd9,
        OP_SLL  = 5'd10,
        OP_SRL  = 5'd11,
        OP_SRA  = 5'd12,
        OP_LUI  = 5'd13
    } opgen_e;

endpackage

// File: rtl/int_exec_unit_alu.sv
// -----------------------------------------------------------------------------
// int_alu
// Purely combinational integer ALU with exception resolution.
// Ports:
//   opgen_i     operation code
//   operand1_i  first operand (value for shifts)
//   operand2_i  second operand (shift amount in [4:0], LUI immediate in [15:0])
//   exc_i       exception already attached upstream
//   result_o    result data (0 whenever an exception is reported)
//   exc_o       final exception type
// -----------------------------------------------------------------------------
module int_alu
    import int_exec_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int EXC_W   = EXC_CODE_W,
    parameter int OPGEN_W = OPGEN_CODE_W
) (
    input  logic [OPGEN_W-1:0] opgen_i,
    input  logic [DATA_W-1:0]  operand1_i,
    input  logic [DATA_W-1:0]  operand2_i,
    input  logic [EXC_W-1:0]   exc_i,
    output logic [DATA_W-1:0]  result_o,
    output logic [EXC_W-1:0]   exc_o
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] raw;
    logic              ovf;
    logic [4:0]        shamt;

    assign sum   = operand1_i + operand2_i;
    assign diff  = operand1_i - operand2_i;
    assign shamt = operand2_i[4:0];

    always_comb begin
        raw = '0;
        ovf = 1'b0;
        case (opgen_i)
            OP_ADD: begin
                raw = sum;
                // same-sign operands producing an opposite-sign sum
                ovf = (operand1_i[MSB] == operand2_i[MSB]) && (sum[MSB] != operand1_i[MSB]);
            end
            OP_ADDU: raw = sum;
            OP_SUB: begin
                raw = diff;
                // differing-sign operands where the result sign flips away from operand1
                ovf = (operand1_i[MSB] != operand2_i[MSB]) && (diff[MSB] != operand1_i[MSB]);
            end
            OP_SUBU: raw = diff;
            OP_AND:  raw = operand1_i & operand2_i;
            OP_OR:   raw = operand1_i | operand2_i;
            OP_XOR:  raw = operand1_i ^ operand2_i;
            OP_NOR:  raw = ~(operand1_i | operand2_i);
            OP_SLT:  raw = {{(DATA_W-1){1'b0}}, ($signed(operand1_i) < $signed(operand2_i))};
            OP_SLTU: raw = {{(DATA_W-1){1'b0}}, (operand1_i < operand2_i)};
            OP_SLL:  raw = operand1_i << shamt;
            OP_SRL:  raw = operand1_i >> shamt;
            OP_SRA:  raw = $signed(operand1_i) >>> shamt;
            OP_LUI:  raw = {operand2_i[15:0], {(DATA_W-16){1'b0}}};
            default: raw = '0;
        endcase
    end

    // Upstream exception wins over overflow; any exception zeroes the data.
    always_comb begin
        result_o = raw;
        exc_o    = EXC_W'(EXC_NONE);
        if (exc_i != EXC_W'(EXC_NONE)) begin
            result_o = '0;
            exc_o    = exc_i;
        end else if (ovf) begin
            result_o = '0;
            exc_o    = EXC_W'(EXC_OVERFLOW);
        end
    end

endmodule

// File: rtl/int_exec_unit.sv
// -----------------------------------------------------------------------------
// int_exec_unit
// Integer execution unit between the integer RS issue and commit channels.
// Accepts one issue per cycle (no backpressure) and returns the result, with
// final exception type, to the RS commit channel.
// Build option: define INT_EXEC_UNIT_PIPE2_EN to register the issued operands
// before the ALU (latency 2); otherwise the ALU feeds the output register
// directly from the issue inputs (latency 1).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop everything in flight and any same-cycle issue
//   issue_*             issued entry: valid, RS line, exc type, opgen, operands
//   rs_commit_*         one-cycle commit pulse with RS line, exc type, data
//   busy                any stage holds a valid operation
// -----------------------------------------------------------------------------
module int_exec_unit
    import int_exec_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RS_ADDR_W = 4,
    parameter int EXC_W     = EXC_CODE_W,
    parameter int OPGEN_W   = OPGEN_CODE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [RS_ADDR_W-1:0] issue_rs_addr,
    input  logic [EXC_W-1:0]     issue_exc_type,
    input  logic [OPGEN_W-1:0]   issue_opgen,
    input  logic [DATA_W-1:0]    issue_operand_1,
    input  logic [DATA_W-1:0]    issue_operand_2,
    output logic                 rs_commit_en,
    output logic [RS_ADDR_W-1:0] rs_commit_addr,
    output logic [EXC_W-1:0]     rs_commit_exc_type,
    output logic [DATA_W-1:0]    rs_commit_data,
    output logic                 busy
);

    logic                 alu_valid;
    logic [RS_ADDR_W-1:0] alu_addr;
    logic [OPGEN_W-1:0]   alu_opgen;
    logic [DATA_W-1:0]    alu_op1;
    logic [DATA_W-1:0]    alu_op2;
    logic [EXC_W-1:0]     alu_exc_in;
    logic [DATA_W-1:0]    alu_result;
    logic [EXC_W-1:0]     alu_exc_out;

`ifdef INT_EXEC_UNIT_PIPE2_EN
    logic                 s1_valid_q, s1_valid_d;
    logic [RS_ADDR_W-1:0] s1_addr_q;
    logic [EXC_W-1:0]     s1_exc_q;
    logic [OPGEN_W-1:0]   s1_opgen_q;
    logic [DATA_W-1:0]    s1_op1_q;
    logic [DATA_W-1:0]    s1_op2_q;

    assign s1_valid_d = issue_valid & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_exc_q   <= '0;
            s1_opgen_q <= '0;
            s1_op1_q   <= '0;
            s1_op2_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= issue_rs_addr;
            s1_exc_q   <= issue_exc_type;
            s1_opgen_q <= issue_opgen;
            s1_op1_q   <= issue_operand_1;
            s1_op2_q   <= issue_operand_2;
        end
    end

    assign alu_valid  = s1_valid_q;
    assign alu_addr   = s1_addr_q;
    assign alu_opgen  = s1_opgen_q;
    assign alu_op1    = s1_op1_q;
    assign alu_op2    = s1_op2_q;
    assign alu_exc_in = s1_exc_q;
`else
    assign alu_valid  = issue_valid;
    assign alu_addr   = issue_rs_addr;
    assign alu_opgen  = issue_opgen;
    assign alu_op1    = issue_operand_1;
    assign alu_op2    = issue_operand_2;
    assign alu_exc_in = issue_exc_type;
`endif

    int_alu #(
        .DATA_W  (DATA_W),
        .EXC_W   (EXC_W),
        .OPGEN_W (OPGEN_W)
    ) u_alu (
        .opgen_i    (alu_opgen),
        .operand1_i (alu_op1),
        .operand2_i (alu_op2),
        .exc_i      (alu_exc_in),
        .result_o   (alu_result),
        .exc_o      (alu_exc_out)
    );

    logic                 out_valid_q, out_valid_d;
    logic [RS_ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [EXC_W-1:0]     out_exc_q, out_exc_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;

    // Payload is zeroed when no commit is issued so the RS never sees stale data.
    always_comb begin
        out_valid_d = alu_valid & ~flush;
        out_addr_d  = '0;
        out_exc_d   = '0;
        out_data_d  = '0;
        if (out_valid_d) begin
            out_addr_d = alu_addr;
            out_exc_d  = alu_exc_out;
            out_data_d = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_exc_q   <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_exc_q   <= out_exc_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rs_commit_en       = out_valid_q;
    assign rs_commit_addr     = out_addr_q;
    assign rs_commit_exc_type = out_exc_q;
    assign rs_commit_data     = out_data_q;

`ifdef INT_EXEC_UNIT_PIPE2_EN
    assign busy = s1_valid_q | out_valid_q;
`else
    assign busy = out_valid_q;
`endif

endmodule

// File: tb/tb_int_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_int_exec_unit
// Self-checking bench for int_exec_unit. Expected commits are kept in a
// timestamped table indexed by the clock edge on whose far side they must be
// visible; each scenario task compares the DUT outputs against it every cycle
// and adds directed constant checks for the notable cases.
// -----------------------------------------------------------------------------
module tb_int_exec_unit;
    import int_exec_unit_pkg::*;

`ifdef INT_EXEC_UNIT_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NWIN = 2048;
    localparam longint MAX_S = 64'sh7FFFFFFF;
    localparam longint MIN_S = -64'sh80000000;

    logic        clk = 1'b0;
    logic        rst, flush, issue_valid;
    logic [3:0]  issue_rs_addr;
    logic [3:0]  issue_exc_type;
    logic [4:0]  issue_opgen;
    logic [31:0] issue_operand_1, issue_operand_2;
    logic        rs_commit_en;
    logic [3:0]  rs_commit_addr;
    logic [3:0]  rs_commit_exc_type;
    logic [31:0] rs_commit_data;
    logic        busy;

    int_exec_unit dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .issue_valid        (issue_valid),
        .issue_rs_addr      (issue_rs_addr),
        .issue_exc_type     (issue_exc_type),
        .issue_opgen        (issue_opgen),
        .issue_operand_1    (issue_operand_1),
        .issue_operand_2    (issue_operand_2),
        .rs_commit_en       (rs_commit_en),
        .rs_commit_addr     (rs_commit_addr),
        .rs_commit_exc_type (rs_commit_exc_type),
        .rs_commit_data     (rs_commit_data),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    logic        exp_en   [NWIN];
    logic [3:0]  exp_addr [NWIN];
    logic [3:0]  exp_exc  [NWIN];
    logic [31:0] exp_data [NWIN];
    int cyc;
    int n_checks;
    int n_fail;

    // Reference: result and final exception type from the operation rules.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] ex, output logic [3:0] eo, output logic [31:0] d);
        longint s;
        logic ovf;
        logic [31:0] r;
        ovf = 1'b0;
        r   = 32'h0;
        case (op)
            OP_ADD:  begin s = longint'(int'(a)) + longint'(int'(b)); ovf = (s > MAX_S) || (s < MIN_S); r = a + b; end
            OP_ADDU: r = a + b;
            OP_SUB:  begin s = longint'(int'(a)) - longint'(int'(b)); ovf = (s > MAX_S) || (s < MIN_S); r = a - b; end
            OP_SUBU: r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  r = 32'(int'(a) >>> b[4:0]);
            OP_LUI:  r = {b[15:0], 16'h0};
            default: r = 32'h0;
        endcase
        if (ex != EXC_NONE) begin
            eo = ex; d = 32'h0;
        end else if (ovf) begin
            eo = EXC_OVERFLOW; d = 32'h0;
        end else begin
            eo = EXC_NONE; d = r;
        end
    endfunction

    function automatic logic exp_busy(input int w);
        logic b;
        b = 1'b0;
        for (int k = 0; k < LAT; k++) b = b | exp_en[w + k];
        return b;
    endfunction

    // Drive one cycle of inputs, update the expectation table, advance one edge.
    task automatic cycle(input logic r, input logic f, input logic v, input logic [3:0] ad,
                         input logic [3:0] ex, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int e;
        logic [3:0] meo;
        logic [31:0] md;
        rst = r; flush = f; issue_valid = v; issue_rs_addr = ad;
        issue_exc_type = ex; issue_opgen = op; issue_operand_1 = a; issue_operand_2 = b;
        e = cyc + 1;
        if (r || f) begin
            for (int w = e; w <= e + LAT; w++) begin
                exp_en[w] = 1'b0; exp_addr[w] = '0; exp_exc[w] = '0; exp_data[w] = '0;
            end
        end else if (v) begin
            model(op, a, b, ex, meo, md);
            exp_en[e+LAT-1]   = 1'b1;
            exp_addr[e+LAT-1] = ad;
            exp_exc[e+LAT-1]  = meo;
            exp_data[e+LAT-1] = md;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) cycle(1'b1, 1'b0, 1'b1, 4'($urandom), 4'h0, OP_ADD, $urandom, $urandom);
            else       idle();
            n_checks++;
            if ({rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy} !== 42'h0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got en=%b addr=%h exc=%h data=%h busy=%b, want all 0",
                         i, rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy);
            end
        end
    endtask

    task automatic test_basic_add();
        for (int i = 0; i <= LAT; i++) begin
            if (i == 0) cycle(1'b0, 1'b0, 1'b1, 4'd5, EXC_NONE, OP_ADD, 32'd3, 32'd4);
            else        idle();
            n_checks++;
            if ({rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy} !==
                {exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc], exp_busy(cyc)}) begin
                n_fail++;
                $display("FAIL basic_add cyc=%0d: got en=%b addr=%h exc=%h data=%h busy=%b want en=%b addr=%h exc=%h data=%h",
                         cyc, rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy,
                         exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc]);
            end
            if (i == LAT - 1) begin
                n_checks++;
                if ({rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data} !== {1'b1, 4'd5, EXC_NONE, 32'd7}) begin
                    n_fail++;
                    $display("FAIL add_3_4: got en=%b addr=%0d exc=%h data=%0d want en=1 addr=5 exc=0 data=7",
                             rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data);
                end
            end
            if (i == LAT) begin
                n_checks++;
                if ({rs_commit_en, rs_commit_data} !== 33'h0) begin
                    n_fail++;
                    $display("FAIL add_pulse_end: got en=%b data=%h want en=0 data=0", rs_commit_en, rs_commit_data);
                end
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < LAT + 4; i++) begin
            case (i)
                0: cycle(1'b0, 1'b0, 1'b1, 4'd1, EXC_NONE, OP_ADD,  32'h7FFFFFFF, 32'h1);
                1: cycle(1'b0, 1'b0, 1'b1, 4'd2, EXC_NONE, OP_ADDU, 32'h7FFFFFFF, 32'h1);
                2: cycle(1'b0, 1'b0, 1'b1, 4'd3, EXC_NONE, OP_SUB,  32'h80000000, 32'h1);
                3: cycle(1'b0, 1'b0, 1'b1, 4'd4, EXC_NONE, OP_SUBU, 32'h80000000, 32'h1);
                default: idle();
            endcase
            n_checks++;
            if ({rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy} !==
                {exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc], exp_busy(cyc)}) begin
                n_fail++;
                $display("FAIL overflow cyc=%0d: got en=%b addr=%h exc=%h data=%h busy=%b want en=%b addr=%h exc=%h data=%h",
                         cyc, rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy,
                         exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc]);
            end
            if (i == LAT - 1) begin
                n_checks++;
                if ({rs_commit_exc_type, rs_commit_data} !== {EXC_OVERFLOW, 32'h0}) begin
                    n_fail++;
                    $display("FAIL add_ovf: got exc=%h data=%h want exc=%h data=0", rs_commit_exc_type, rs_commit_data, EXC_OVERFLOW);
                end
            end
            if (i == LAT) begin
                n_checks++;
                if ({rs_commit_exc_type, rs_commit_data} !== {EXC_NONE, 32'h80000000}) begin
                    n_fail++;
                    $display("FAIL addu_wrap: got exc=%h data=%h want exc=0 data=80000000", rs_commit_exc_type, rs_commit_data);
                end
            end
        end
    endtask

    task automatic test_input_exc();
        for (int i = 0; i <= LAT; i++) begin
            if (i == 0) cycle(1'b0, 1'b0, 1'b1, 4'd9, 4'h3, OP_SUB, 32'h80000000, 32'h1);
            else        idle();
            n_checks++;
            if ({rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy} !==
                {exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc], exp_busy(cyc)}) begin
                n_fail++;
                $display("FAIL input_exc cyc=%0d: got en=%b addr=%h exc=%h data=%h busy=%b want en=%b addr=%h exc=%h data=%h",
                         cyc, rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy,
                         exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc]);
            end
            if (i == LAT - 1) begin
                n_checks++;
                if ({rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data} !== {1'b1, 4'd9, 4'h3, 32'h0}) begin
                    n_fail++;
                    $display("FAIL exc_passthru: got en=%b addr=%h exc=%h data=%h want en=1 addr=9 exc=3 data=0",
                             rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_commit;
        logic [4:0] op;
        logic [31:0] a, b;
        n_commit = 0;
        for (int i = 0; i < 16 + LAT + 1; i++) begin
            if (i < 16) begin
                case (i % 3)
                    0: op = OP_SLL;
                    1: op = OP_SRA;
                    default: op = OP_SLTU;
                endcase
                a = $urandom;
                b = $urandom;
                if (i == 1) begin a = 32'h80000000; b = 32'd4; end
                if (i == 2) begin a = 32'h1; b = 32'hFFFFFFFF; end
                cycle(1'b0, 1'b0, 1'b1, 4'(i), EXC_NONE, op, a, b);
            end else begin
                idle();
            end
            n_checks++;
            if ({rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy} !==
                {exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc], exp_busy(cyc)}) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d: got en=%b addr=%h exc=%h data=%h busy=%b want en=%b addr=%h exc=%h data=%h",
                         cyc, rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy,
                         exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc]);
            end
            if (i >= LAT - 1 && i < LAT - 1 + 16) begin
                n_checks++;
                if ({rs_commit_en, rs_commit_addr} !== {1'b1, 4'(n_commit)}) begin
                    n_fail++;
                    $display("FAIL b2b_order: got en=%b addr=%0d want en=1 addr=%0d", rs_commit_en, rs_commit_addr, n_commit);
                end
                if (n_commit == 1 || n_commit == 2) begin
                    n_checks++;
                    if (rs_commit_data !== ((n_commit == 1) ? 32'hF8000000 : 32'h1)) begin
                        n_fail++;
                        $display("FAIL b2b_value[%0d]: got data=%h want %h", n_commit, rs_commit_data,
                                 (n_commit == 1) ? 32'hF8000000 : 32'h1);
                    end
                end
            end
            if (rs_commit_en === 1'b1) n_commit++;
        end
        n_checks++;
        if (n_commit != 16) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d commits want 16", n_commit);
        end
    endtask

    task automatic test_flush();
        int n_commit;
        int want;
        n_commit = 0;
        want = (LAT == 1) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: cycle(1'b0, 1'b0, 1'b1, 4'd11, EXC_NONE, OP_ADD, 32'd1, 32'd1);
                1: cycle(1'b0, 1'b1, 1'b1, 4'd12, EXC_NONE, OP_ADD, 32'd2, 32'd2);
                default: idle();
            endcase
            n_checks++;
            if ({rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy} !==
                {exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc], exp_busy(cyc)}) begin
                n_fail++;
                $display("FAIL flush cyc=%0d: got en=%b addr=%h exc=%h data=%h busy=%b want en=%b addr=%h exc=%h data=%h",
                         cyc, rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy,
                         exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc]);
            end
            if (rs_commit_en === 1'b1) n_commit++;
            if (i == 3) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_busy: got busy=%b want 0", busy);
                end
            end
        end
        n_checks++;
        if (n_commit != want) begin
            n_fail++;
            $display("FAIL flush_count: got %0d commits want %0d", n_commit, want);
        end
    endtask

    task automatic test_random();
        logic v, f;
        logic [3:0] ex;
        logic [31:0] a, b;
        for (int i = 0; i < 400; i++) begin
            if (i < 400 - LAT - 1) begin
                v  = ($urandom_range(0, 3) != 0);
                f  = ($urandom_range(0, 19) == 0);
                ex = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : EXC_NONE;
                a  = $urandom;
                b  = $urandom;
                case ($urandom_range(0, 5))
                    0: a = 32'h7FFFFFFF;
                    1: a = 32'h80000000;
                    2: b = 32'h80000000;
                    default: ;
                endcase
                cycle(1'b0, f, v, 4'($urandom), ex, 5'($urandom_range(0, 17)), a, b);
            end else begin
                idle();
            end
            n_checks++;
            if ({rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy} !==
                {exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc], exp_busy(cyc)}) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got en=%b addr=%h exc=%h data=%h busy=%b want en=%b addr=%h exc=%h data=%h",
                         cyc, rs_commit_en, rs_commit_addr, rs_commit_exc_type, rs_commit_data, busy,
                         exp_en[cyc], exp_addr[cyc], exp_exc[cyc], exp_data[cyc]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int w = 0; w < NWIN; w++) begin
            exp_en[w] = 1'b0; exp_addr[w] = '0; exp_exc[w] = '0; exp_data[w] = '0;
        end
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_rs_addr = '0;
        issue_exc_type = '0; issue_opgen = '0; issue_operand_1 = '0; issue_operand_2 = '0;

        test_reset();
        test_basic_add();
        test_overflow();
        test_input_exc();
        test_back_to_back();
        test_flush();
        test_random();
        // reset in the middle of a burst kills everything in flight
        cycle(1'b0, 1'b0, 1'b1, 4'd6, EXC_NONE, OP_OR, 32'hF0, 32'h0F);
        test_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
